// File: rtl/param_commit_ctrl_if.sv
// Bundles the ADC parameter inputs and the committed datapath outputs of param_commit_ctrl.
// The controller connects through the slave modport; the driver of the ADC inputs uses master.
interface param_commit_ctrl_if #(
  parameter int unsigned DIV_BIT = 9
);
  logic                i_Data_Received;
  logic [15:0]         i_Data0;
  logic [15:0]         i_Data1;
  logic [15:0]         i_Data2;
  logic [15:0]         i_Data3;
  logic                i_Frame_Start;
  logic                i_Clear_Err;
  logic [15:0]         o_Frequency;
  logic [DIV_BIT-1:0]  o_Harmonic_Scale;
  logic [DIV_BIT-1:0]  o_Scale_Initial;
  logic [15:0]         o_Freq_Scale;
  logic                o_Update;
  logic                o_Pending;
  logic                o_Overrun;

  modport slave (
    input  i_Data_Received, i_Data0, i_Data1, i_Data2, i_Data3, i_Frame_Start, i_Clear_Err,
    output o_Frequency, o_Harmonic_Scale, o_Scale_Initial, o_Freq_Scale, o_Update, o_Pending, o_Overrun
  );

  modport master (
    output i_Data_Received, i_Data0, i_Data1, i_Data2, i_Data3, i_Frame_Start, i_Clear_Err,
    input  o_Frequency, o_Harmonic_Scale, o_Scale_Initial, o_Freq_Scale, o_Update, o_Pending, o_Overrun
  );
endinterface

// File: rtl/param_commit_ctrl.sv
// Shadow-banks ADC parameter sets and commits them to the harmonic datapath only on frame
// boundaries, slew-limiting the frequency by at most MAX_STEP per frame.
module param_commit_ctrl #(
  parameter int unsigned DIV_BIT   = 9,
  parameter logic [15:0] INIT_FREQ = 16'd1000,
  parameter logic [15:0] FREQ_MIN  = 16'd16,
  parameter logic [15:0] FREQ_MAX  = 16'd60000,
  parameter logic [15:0] MAX_STEP  = 16'd256
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  param_commit_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;
  localparam logic [DIV_BIT-1:0] SCALE_ONES = {DIV_BIT{1'b1}};
  localparam logic [DIV_BIT-1:0] SCALE_ZERO = {DIV_BIT{1'b0}};

  function automatic logic [15:0] clamp_freq(input logic [15:0] f);
    if (f < FREQ_MIN) begin
      clamp_freq = FREQ_MIN;
    end else if (f > FREQ_MAX) begin
      clamp_freq = FREQ_MAX;
    end else begin
      clamp_freq = f;
    end
  endfunction

  // 17-bit signed distance so the step never wraps around 0 or 65535.
  function automatic logic [15:0] slew_step(input logic [15:0] cur, input logic [15:0] tgt);
    logic signed [16:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > $signed({1'b0, MAX_STEP})) begin
      slew_step = cur + MAX_STEP;
    end else if (diff < -$signed({1'b0, MAX_STEP})) begin
      slew_step = cur - MAX_STEP;
    end else begin
      slew_step = tgt;
    end
  endfunction

  logic [1:0]         state_q, state_d;
  logic               dr_q, armed_q;
  logic [15:0]        sh_freq_q, sh_freq_d, sh_fsc_q, sh_fsc_d;
  logic [DIV_BIT-1:0] sh_hs_q, sh_hs_d, sh_si_q, sh_si_d;
  logic [15:0]        tgt_q, tgt_d, freq_q, freq_d, fsc_q, fsc_d;
  logic [DIV_BIT-1:0] hs_q, hs_d, si_q, si_d;
  logic               upd_q, upd_d, pend_q, pend_d, ovr_q, ovr_d;
  logic               capture_s;
  logic               unused_bits_s;

  // armed_q masks the first cycle after reset so a level still high from before reset is not a new edge.
  assign capture_s     = bus.i_Data_Received & ~dr_q & armed_q;
  assign unused_bits_s = ^{bus.i_Data1[15:DIV_BIT], bus.i_Data2[15:DIV_BIT]};

  // Next-state logic: capture, frame commit, idle slew, sticky overrun and update pulse.
  always_comb begin
    state_d   = state_q;
    sh_freq_d = sh_freq_q;
    sh_hs_d   = sh_hs_q;
    sh_si_d   = sh_si_q;
    sh_fsc_d  = sh_fsc_q;
    tgt_d     = tgt_q;
    freq_d    = freq_q;
    hs_d      = hs_q;
    si_d      = si_q;
    fsc_d     = fsc_q;
    pend_d    = pend_q;

    if (bus.i_Clear_Err) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    if (capture_s) begin
      sh_freq_d = clamp_freq(bus.i_Data0);
      sh_hs_d   = bus.i_Data1[DIV_BIT-1:0];
      sh_si_d   = bus.i_Data2[DIV_BIT-1:0];
      sh_fsc_d  = bus.i_Data3;
    end else begin
      sh_freq_d = sh_freq_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (capture_s) begin
          state_d = ST_PENDING;
          pend_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
        // A frame start here only slews; data captured in the same cycle waits a frame.
        if (bus.i_Frame_Start) begin
          freq_d = slew_step(freq_q, tgt_q);
        end else begin
          freq_d = freq_q;
        end
      end
      ST_PENDING: begin
        if (capture_s) begin
          ovr_d = 1'b1;
        end else begin
          ovr_d = ovr_d;
        end
        if (bus.i_Frame_Start) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_PENDING;
        end
      end
      ST_COMMIT: begin
        tgt_d  = sh_freq_q;
        hs_d   = sh_hs_q;
        si_d   = sh_si_q;
        fsc_d  = sh_fsc_q;
        freq_d = slew_step(freq_q, sh_freq_q);
        if (capture_s) begin
          state_d = ST_PENDING;
          pend_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end
    endcase

    upd_d = (freq_d != freq_q) | (hs_d != hs_q) | (si_d != si_q) | (fsc_d != fsc_q);
  end

  // State and output registers; reset discards the shadow bank without an update pulse.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= ST_IDLE;
      dr_q      <= 1'b0;
      armed_q   <= 1'b0;
      sh_freq_q <= INIT_FREQ;
      sh_hs_q   <= SCALE_ZERO;
      sh_si_q   <= SCALE_ONES;
      sh_fsc_q  <= 16'd0;
      tgt_q     <= INIT_FREQ;
      freq_q    <= INIT_FREQ;
      hs_q      <= SCALE_ZERO;
      si_q      <= SCALE_ONES;
      fsc_q     <= 16'd0;
      upd_q     <= 1'b0;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dr_q      <= bus.i_Data_Received;
      armed_q   <= 1'b1;
      sh_freq_q <= sh_freq_d;
      sh_hs_q   <= sh_hs_d;
      sh_si_q   <= sh_si_d;
      sh_fsc_q  <= sh_fsc_d;
      tgt_q     <= tgt_d;
      freq_q    <= freq_d;
      hs_q      <= hs_d;
      si_q      <= si_d;
      fsc_q     <= fsc_d;
      upd_q     <= upd_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.o_Frequency      = freq_q;
  assign bus.o_Harmonic_Scale = hs_q;
  assign bus.o_Scale_Initial  = si_q;
  assign bus.o_Freq_Scale     = fsc_q;
  assign bus.o_Update         = upd_q;
  assign bus.o_Pending        = pend_q;
  assign bus.o_Overrun        = ovr_q;

endmodule

// File: tb/tb_param_commit_ctrl.sv
// Bench for param_commit_ctrl: directed table, hand-written corner sequences and random traffic,
// all compared every cycle against an event-level reference model.
module tb_param_commit_ctrl;
  localparam int DIV_BIT = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_commit_ctrl_if #(.DIV_BIT(DIV_BIT)) bus();

  param_commit_ctrl #(.DIV_BIT(DIV_BIT)) dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .bus       (bus.slave)
  );

  int total = 0;
  int bad = 0;

  // Reference model: committed outputs, shadow bank, and frame-level flags.
  int m_freq, m_tgt, m_hs, m_si, m_fsc;
  int s_freq, s_hs, s_si, s_fsc;
  bit m_pend, m_ovr, m_upd, m_commit, m_prev, m_armed;

  typedef struct {
    bit          dr;
    logic [15:0] d0, d1, d2, d3;
    bit          fs;
    int          e_freq, e_hs, e_si, e_fsc;
    bit          e_pend, e_upd, e_ovr;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampf(input int f);
    if (f < 16) return 16;
    if (f > 60000) return 60000;
    return f;
  endfunction

  function automatic int slew(input int cur, input int tgt);
    int d;
    d = tgt - cur;
    if (d > 256) return cur + 256;
    if (d < -256) return cur - 256;
    return tgt;
  endfunction

  task automatic model_reset();
    m_freq = 1000; m_tgt = 1000; m_hs = 0; m_si = 511; m_fsc = 0;
    s_freq = 1000; s_hs = 0; s_si = 511; s_fsc = 0;
    m_pend = 0; m_ovr = 0; m_upd = 0; m_commit = 0; m_prev = 0; m_armed = 0;
  endtask

  task automatic model_tick();
    bit cap, was_commit;
    int of, oh, os, oc;
    cap = bus.i_Data_Received && !m_prev && m_armed;
    m_prev = bus.i_Data_Received;
    m_armed = 1;
    was_commit = m_commit;
    of = m_freq; oh = m_hs; os = m_si; oc = m_fsc;
    if (was_commit) begin
      m_tgt = s_freq; m_hs = s_hs; m_si = s_si; m_fsc = s_fsc;
      m_freq = slew(m_freq, m_tgt);
      m_commit = 0;
    end else if (m_pend) begin
      m_commit = bus.i_Frame_Start;
    end else if (bus.i_Frame_Start) begin
      m_freq = slew(m_freq, m_tgt);
    end
    if (cap && m_pend && !was_commit) m_ovr = 1;
    else if (bus.i_Clear_Err) m_ovr = 0;
    if (cap) begin
      m_pend = 1;
      s_freq = clampf(int'(bus.i_Data0));
      s_hs = int'(bus.i_Data1) % 512;
      s_si = int'(bus.i_Data2) % 512;
      s_fsc = int'(bus.i_Data3);
    end else if (was_commit) begin
      m_pend = 0;
    end
    m_upd = (of != m_freq) || (oh != m_hs) || (os != m_si) || (oc != m_fsc);
  endtask

  task automatic drive(input bit dr, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3, input bit fs, input bit clr);
    bus.i_Data_Received = dr; bus.i_Data0 = d0; bus.i_Data1 = d1;
    bus.i_Data2 = d2; bus.i_Data3 = d3; bus.i_Frame_Start = fs; bus.i_Clear_Err = clr;
  endtask

  task automatic cyc();
    model_tick();
    @(posedge clk);
    #1;
    chk("freq", int'(bus.o_Frequency), m_freq);
    chk("hscale", int'(bus.o_Harmonic_Scale), m_hs);
    chk("sinit", int'(bus.o_Scale_Initial), m_si);
    chk("fscale", int'(bus.o_Freq_Scale), m_fsc);
    chk("update", int'(bus.o_Update), int'(m_upd));
    chk("pending", int'(bus.o_Pending), int'(m_pend));
    chk("overrun", int'(bus.o_Overrun), int'(m_ovr));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_freq"}, int'(bus.o_Frequency), 1000);
    chk({tag, "_hs"}, int'(bus.o_Harmonic_Scale), 0);
    chk({tag, "_si"}, int'(bus.o_Scale_Initial), 511);
    chk({tag, "_fsc"}, int'(bus.o_Freq_Scale), 0);
    chk({tag, "_upd"}, int'(bus.o_Update), 0);
    chk({tag, "_pend"}, int'(bus.o_Pending), 0);
    chk({tag, "_ovr"}, int'(bus.o_Overrun), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic capture(input logic [15:0] f, input logic [15:0] d1, input logic [15:0] d2,
                         input logic [15:0] d3);
    drive(1'b1, f, d1, d2, d3, 1'b0, 1'b0);
    cyc();
    drive(1'b0, f, d1, d2, d3, 1'b0, 1'b0);
    cyc();
  endtask

  task automatic frame();
    bus.i_Frame_Start = 1'b1;
    cyc();
    bus.i_Frame_Start = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    drive(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);

    // Reset state and frame starts with no ADC traffic.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      frame();
      chk("idle_freq", int'(bus.o_Frequency), 1000);
      chk("idle_si", int'(bus.o_Scale_Initial), 511);
      chk("idle_upd", int'(bus.o_Update), 0);
    end

    // Directed table: commit latency, truncation, low clamp and idle slew.
    tbl[0] = '{1'b1, 16'd1100, 16'h0123, 16'h01FF, 16'd5, 1'b0, 1000, 0,     511, 0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'd1100, 16'h0123, 16'h01FF, 16'd5, 1'b0, 1000, 0,     511, 0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 16'd0,    16'h0000, 16'h0000, 16'd0, 1'b1, 1000, 0,     511, 0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 16'd0,    16'h0000, 16'h0000, 16'd0, 1'b0, 1100, 'h123, 511, 5, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 16'd0,    16'h0000, 16'h0000, 16'd0, 1'b0, 1100, 'h123, 511, 5, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 16'd5,    16'hFFFF, 16'h0000, 16'd7, 1'b0, 1100, 'h123, 511, 5, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 16'd5,    16'hFFFF, 16'h0000, 16'd7, 1'b1, 1100, 'h123, 511, 5, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 16'd5,    16'hFFFF, 16'h0000, 16'd7, 1'b0, 844,  'h1FF, 0,   7, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 16'd5,    16'hFFFF, 16'h0000, 16'd7, 1'b1, 588,  'h1FF, 0,   7, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].dr, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3, tbl[i].fs, 1'b0);
      cyc();
      chk($sformatf("tbl%0d_freq", i), int'(bus.o_Frequency), tbl[i].e_freq);
      chk($sformatf("tbl%0d_hs", i), int'(bus.o_Harmonic_Scale), tbl[i].e_hs);
      chk($sformatf("tbl%0d_si", i), int'(bus.o_Scale_Initial), tbl[i].e_si);
      chk($sformatf("tbl%0d_fsc", i), int'(bus.o_Freq_Scale), tbl[i].e_fsc);
      chk($sformatf("tbl%0d_pend", i), int'(bus.o_Pending), int'(tbl[i].e_pend));
      chk($sformatf("tbl%0d_upd", i), int'(bus.o_Update), int'(tbl[i].e_upd));
      chk($sformatf("tbl%0d_ovr", i), int'(bus.o_Overrun), int'(tbl[i].e_ovr));
    end
    bus.i_Frame_Start = 1'b0;

    // Slew from 1000 to 2000 in MAX_STEP increments, then silence.
    do_reset();
    capture(16'd2000, 16'd0, 16'd511, 16'd0);
    frame(); chk("slew1", int'(bus.o_Frequency), 1256);
    frame(); chk("slew2", int'(bus.o_Frequency), 1512);
    frame(); chk("slew3", int'(bus.o_Frequency), 1768);
    frame(); chk("slew4", int'(bus.o_Frequency), 2000);
    bus.i_Frame_Start = 1'b1;
    cyc();
    bus.i_Frame_Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("slew_done_upd", int'(bus.o_Update), 0);
      cyc();
    end

    // Overrun on double capture; the later data is the one committed.
    do_reset();
    capture(16'd3000, 16'd1, 16'd2, 16'd3);
    capture(16'd4000, 16'd4, 16'd5, 16'd6);
    chk("ovr_set", int'(bus.o_Overrun), 1);
    frame();
    chk("ovr_commit_freq", int'(bus.o_Frequency), 1256);
    chk("ovr_commit_hs", int'(bus.o_Harmonic_Scale), 4);
    for (int i = 0; i < 11; i++) frame();
    chk("ovr_target", int'(bus.o_Frequency), 4000);
    bus.i_Clear_Err = 1'b1;
    cyc();
    bus.i_Clear_Err = 1'b0;
    chk("ovr_clear", int'(bus.o_Overrun), 0);

    // Upper clamp: 65535 settles at 60000.
    capture(16'd65535, 16'd0, 16'd0, 16'd0);
    for (int i = 0; i < 230; i++) frame();
    chk("clamp_hi", int'(bus.o_Frequency), 60000);

    // Reset while pending with the data-received level held high.
    do_reset();
    drive(1'b1, 16'd7000, 16'd9, 16'd9, 16'd9, 1'b0, 1'b0);
    cyc();
    cyc();
    chk("rst_pend_before", int'(bus.o_Pending), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("held_no_capture", int'(bus.o_Pending), 0);
    bus.i_Data_Received = 1'b0;
    cyc();
    bus.i_Data_Received = 1'b1;
    cyc();
    chk("recapture", int'(bus.o_Pending), 1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.i_Data_Received = ~bus.i_Data_Received;
      bus.i_Data0 = 16'($urandom_range(0, 65535));
      bus.i_Data1 = 16'($urandom_range(0, 65535));
      bus.i_Data2 = 16'($urandom_range(0, 65535));
      bus.i_Data3 = 16'($urandom_range(0, 65535));
      bus.i_Frame_Start = ($urandom_range(0, 5) == 0);
      bus.i_Clear_Err = ($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
